// File: rtl/fetch_queue.sv
// fetch_queue: two-wide instruction fetch queue with compacting enqueue and in-order dual-slot dequeue
module fetch_queue #(
  parameter int DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_i_flush,
  input  logic        io_i_fetch_pack_valid,
  input  logic        io_i_fetch_pack_bits_valids_0,
  input  logic        io_i_fetch_pack_bits_valids_1,
  input  logic [63:0] io_i_fetch_pack_bits_pc,
  input  logic [31:0] io_i_fetch_pack_bits_insts_0,
  input  logic [31:0] io_i_fetch_pack_bits_insts_1,
  input  logic        io_i_fetch_pack_bits_branch_predict_pack_valid,
  input  logic [63:0] io_i_fetch_pack_bits_branch_predict_pack_target,
  input  logic [3:0]  io_i_fetch_pack_bits_branch_predict_pack_branch_type,
  input  logic        io_i_fetch_pack_bits_branch_predict_pack_select,
  input  logic        io_i_fetch_pack_bits_branch_predict_pack_taken,
  output logic        io_o_fetch_pack_ready,
  input  logic        io_i_decode_ready,
  output logic        io_o_slot_0_valid,
  output logic [63:0] io_o_slot_0_pc,
  output logic [31:0] io_o_slot_0_inst,
  output logic        io_o_slot_0_bp_valid,
  output logic [63:0] io_o_slot_0_bp_target,
  output logic [3:0]  io_o_slot_0_bp_branch_type,
  output logic        io_o_slot_0_bp_taken,
  output logic        io_o_slot_1_valid,
  output logic [63:0] io_o_slot_1_pc,
  output logic [31:0] io_o_slot_1_inst,
  output logic        io_o_slot_1_bp_valid,
  output logic [63:0] io_o_slot_1_bp_target,
  output logic [3:0]  io_o_slot_1_bp_branch_type,
  output logic        io_o_slot_1_bp_taken
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [63:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic          bpv_mem  [DEPTH];
  logic [63:0]   bpt_mem  [DEPTH];
  logic [3:0]    bpty_mem [DEPTH];
  logic          bptk_mem [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, head_1, tail_1;
  logic [CW-1:0] count_q, count_d, n_enq, n_deq;
  logic          enq, deq, wr_a, wr_b, a_bpv, b_bpv;
  logic [63:0]   a_pc, b_pc;
  logic [31:0]   a_inst;
  assign io_o_fetch_pack_ready = (CW'(DEPTH) - count_q) >= CW'(2);
  assign io_o_slot_0_valid = count_q >= CW'(1);
  assign io_o_slot_1_valid = count_q >= CW'(2);
  assign head_1 = head_q + AW'(1);
  assign tail_1 = tail_q + AW'(1);
  assign io_o_slot_0_pc             = pc_mem[head_q];
  assign io_o_slot_0_inst           = inst_mem[head_q];
  assign io_o_slot_0_bp_valid       = bpv_mem[head_q];
  assign io_o_slot_0_bp_target      = bpt_mem[head_q];
  assign io_o_slot_0_bp_branch_type = bpty_mem[head_q];
  assign io_o_slot_0_bp_taken       = bptk_mem[head_q];
  assign io_o_slot_1_pc             = pc_mem[head_1];
  assign io_o_slot_1_inst           = inst_mem[head_1];
  assign io_o_slot_1_bp_valid       = bpv_mem[head_1];
  assign io_o_slot_1_bp_target      = bpt_mem[head_1];
  assign io_o_slot_1_bp_branch_type = bpty_mem[head_1];
  assign io_o_slot_1_bp_taken       = bptk_mem[head_1];
  // next pointers/count plus compacted write data; entry A is the first valid slot, entry B exists only when both are valid
  always_comb begin
    enq     = io_i_fetch_pack_valid & io_o_fetch_pack_ready & ~io_i_flush;
    deq     = io_i_decode_ready & ~io_i_flush;
    n_enq   = enq ? CW'(io_i_fetch_pack_bits_valids_0) + CW'(io_i_fetch_pack_bits_valids_1) : '0;
    n_deq   = deq ? CW'(io_o_slot_0_valid) + CW'(io_o_slot_1_valid) : '0;
    head_d  = io_i_flush ? '0 : head_q + AW'(n_deq);
    tail_d  = io_i_flush ? '0 : tail_q + AW'(n_enq);
    count_d = io_i_flush ? '0 : count_q + n_enq - n_deq;
    b_pc    = io_i_fetch_pack_bits_pc + 64'd4;
    a_pc    = io_i_fetch_pack_bits_bits_valids_sel_pc();
    a_inst  = io_i_fetch_pack_bits_valids_0 ? io_i_fetch_pack_bits_insts_0 : io_i_fetch_pack_bits_insts_1;
    a_bpv   = io_i_fetch_pack_bits_branch_predict_pack_valid &
              (io_i_fetch_pack_bits_branch_predict_pack_select == ~io_i_fetch_pack_bits_valids_0);
    b_bpv   = io_i_fetch_pack_bits_branch_predict_pack_valid & io_i_fetch_pack_bits_branch_predict_pack_select;
    wr_a    = reset & enq & (io_i_fetch_pack_bits_valids_0 | io_i_fetch_pack_bits_valids_1);
    wr_b    = reset & enq & io_i_fetch_pack_bits_valids_0 & io_i_fetch_pack_bits_valids_1;
  end
  function automatic logic [63:0] io_i_fetch_pack_bits_bits_valids_sel_pc();
    return io_i_fetch_pack_bits_valids_0 ? io_i_fetch_pack_bits_pc : io_i_fetch_pack_bits_pc + 64'd4;
  endfunction
  // entry storage; contents are never cleared, only pointers and count are
  always_ff @(posedge clock) begin
    if (wr_a) begin
      pc_mem[tail_q]   <= a_pc;
      inst_mem[tail_q] <= a_inst;
      bpv_mem[tail_q]  <= a_bpv;
      bpt_mem[tail_q]  <= io_i_fetch_pack_bits_branch_predict_pack_target;
      bpty_mem[tail_q] <= io_i_fetch_pack_bits_branch_predict_pack_branch_type;
      bptk_mem[tail_q] <= io_i_fetch_pack_bits_branch_predict_pack_taken;
    end
    if (wr_b) begin
      pc_mem[tail_1]   <= b_pc;
      inst_mem[tail_1] <= io_i_fetch_pack_bits_insts_1;
      bpv_mem[tail_1]  <= b_bpv;
      bpt_mem[tail_1]  <= io_i_fetch_pack_bits_branch_predict_pack_target;
      bpty_mem[tail_1] <= io_i_fetch_pack_bits_branch_predict_pack_branch_type;
      bptk_mem[tail_1] <= io_i_fetch_pack_bits_branch_predict_pack_taken;
    end
  end
  // pointer and count registers; reset wins over flush, enqueue and dequeue
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with directed packs, fill/wrap, flush and reset
module tb_fetch_queue;
  localparam int DEPTH = 16;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        bpv;
    logic [63:0] bpt;
    logic [3:0]  bpty;
    logic        bptk;
  } ent_t;
  logic clock = 0, reset = 0, flush = 0, fp_valid = 0, v0 = 0, v1 = 0;
  logic pv = 0, sel = 0, tk = 0, dec_rdy = 0;
  logic [63:0] pc = '0, tgt = '0;
  logic [31:0] i0 = '0, i1 = '0;
  logic [3:0]  bty = '0;
  logic rdy, s0_v, s1_v, s0_bpv, s1_bpv, s0_tk, s1_tk;
  logic [63:0] s0_pc, s1_pc, s0_tgt, s1_tgt;
  logic [31:0] s0_inst, s1_inst;
  logic [3:0]  s0_ty, s1_ty;
  ent_t q[$];
  ent_t s0, s1;
  int errors = 0, checks = 0;
  bit mon_en = 0;
  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .io_i_flush(flush),
    .io_i_fetch_pack_valid(fp_valid),
    .io_i_fetch_pack_bits_valids_0(v0), .io_i_fetch_pack_bits_valids_1(v1),
    .io_i_fetch_pack_bits_pc(pc),
    .io_i_fetch_pack_bits_insts_0(i0), .io_i_fetch_pack_bits_insts_1(i1),
    .io_i_fetch_pack_bits_branch_predict_pack_valid(pv),
    .io_i_fetch_pack_bits_branch_predict_pack_target(tgt),
    .io_i_fetch_pack_bits_branch_predict_pack_branch_type(bty),
    .io_i_fetch_pack_bits_branch_predict_pack_select(sel),
    .io_i_fetch_pack_bits_branch_predict_pack_taken(tk),
    .io_o_fetch_pack_ready(rdy), .io_i_decode_ready(dec_rdy),
    .io_o_slot_0_valid(s0_v), .io_o_slot_0_pc(s0_pc), .io_o_slot_0_inst(s0_inst),
    .io_o_slot_0_bp_valid(s0_bpv), .io_o_slot_0_bp_target(s0_tgt),
    .io_o_slot_0_bp_branch_type(s0_ty), .io_o_slot_0_bp_taken(s0_tk),
    .io_o_slot_1_valid(s1_v), .io_o_slot_1_pc(s1_pc), .io_o_slot_1_inst(s1_inst),
    .io_o_slot_1_bp_valid(s1_bpv), .io_o_slot_1_bp_target(s1_tgt),
    .io_o_slot_1_bp_branch_type(s1_ty), .io_o_slot_1_bp_taken(s1_tk)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // monitor: compares presented slots against the scoreboard head and pops on each decode handshake
  always @(negedge clock) begin
    if (mon_en && reset) begin
      s0 = '{s0_pc, s0_inst, s0_bpv, s0_tgt, s0_ty, s0_tk};
      s1 = '{s1_pc, s1_inst, s1_bpv, s1_tgt, s1_ty, s1_tk};
      chk("slot0_valid", 192'(s0_v), 192'(q.size() >= 1));
      chk("slot1_valid", 192'(s1_v), 192'(q.size() >= 2));
      chk("pack_ready", 192'(rdy), 192'((DEPTH - q.size()) >= 2));
      if (q.size() >= 1) chk("slot0_entry", 192'(s0), 192'(q[0]));
      if (q.size() >= 2) chk("slot1_entry", 192'(s1), 192'(q[1]));
      if (dec_rdy && !flush) repeat (q.size() >= 2 ? 2 : q.size()) void'(q.pop_front());
    end
  end
  // drive one pack for one edge; acc says whether the pack is expected to be taken
  task automatic step(input bit a, input bit b, input logic [63:0] p, input logic [31:0] x0, input logic [31:0] x1,
                      input bit bv, input bit s, input logic [63:0] t, input logic [3:0] ty, input bit k, input bit acc);
    fp_valid = 1; v0 = a; v1 = b; pc = p; i0 = x0; i1 = x1; pv = bv; sel = s; tgt = t; bty = ty; tk = k;
    @(posedge clock); #1;
    if (acc) begin
      if (a) q.push_back('{p, x0, bv & !s, t, ty, k});
      if (b) q.push_back('{p + 64'd4, x1, bv & s, t, ty, k});
    end
    fp_valid = 0; v0 = 0; v1 = 0; pv = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask
  task automatic pair(input logic [63:0] p, input logic [31:0] x);
    step(1, 1, p, x, x + 32'd1, 0, 0, '0, '0, 0, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    idle(2);
    reset = 1; mon_en = 1;
    idle(2);
    step(1, 1, 64'h1000, 32'hA, 32'hB, 0, 0, '0, '0, 0, 1);
    @(negedge clock);
    chk("basic_s0_pc", 192'(s0_pc), 192'(64'h1000));
    chk("basic_s0_inst", 192'(s0_inst), 192'(32'hA));
    chk("basic_s1_pc", 192'(s1_pc), 192'(64'h1004));
    chk("basic_s1_inst", 192'(s1_inst), 192'(32'hB));
    @(posedge clock); #1;
    dec_rdy = 1; idle(1); dec_rdy = 0;
    step(0, 1, 64'h2000, 32'h0, 32'hC, 0, 0, '0, '0, 0, 1);
    @(negedge clock);
    chk("misal_s0_pc", 192'(s0_pc), 192'(64'h2004));
    chk("misal_s0_inst", 192'(s0_inst), 192'(32'hC));
    chk("misal_s1_valid", 192'(s1_v), 192'(1'b0));
    @(posedge clock); #1;
    step(0, 0, 64'h2100, 32'h11, 32'h12, 0, 0, '0, '0, 0, 1);
    step(1, 0, 64'h2200, 32'h13, 32'h14, 1, 0, 64'h77, 4'h3, 1, 1);
    dec_rdy = 1; idle(2); dec_rdy = 0;
    step(1, 1, 64'h4000, 32'h1, 32'h2, 1, 1, 64'h3000, 4'h2, 1, 1);
    @(negedge clock);
    chk("bp_s1_valid", 192'(s1_bpv), 192'(1'b1));
    chk("bp_s1_target", 192'(s1_tgt), 192'(64'h3000));
    chk("bp_s0_valid", 192'(s0_bpv), 192'(1'b0));
    @(posedge clock); #1;
    step(1, 1, 64'h4008, 32'h3, 32'h4, 1, 0, 64'h3100, 4'h5, 0, 1);
    dec_rdy = 1; idle(2); dec_rdy = 0;
    for (int k = 0; k < 8; k++) pair(64'h5000 + 64'(8 * k), 32'(16 * k));
    @(negedge clock);
    chk("full_ready", 192'(rdy), 192'(1'b0));
    @(posedge clock); #1;
    step(1, 1, 64'h5F00, 32'hEE, 32'hEF, 0, 0, '0, '0, 0, 0);
    dec_rdy = 1; idle(1); dec_rdy = 0;
    @(negedge clock);
    chk("pop2_ready", 192'(rdy), 192'(1'b1));
    @(posedge clock); #1;
    pair(64'h6000, 32'h600);
    dec_rdy = 1;
    step(0, 1, 64'h6100, 32'h0, 32'h610, 0, 0, '0, '0, 0, 0);
    idle(9); dec_rdy = 0;
    step(1, 0, 64'h6200, 32'h620, 32'h0, 0, 0, '0, '0, 0, 1);
    dec_rdy = 1;
    pair(64'h6300, 32'h630);
    idle(2); dec_rdy = 0;
    for (int k = 0; k < 3; k++) pair(64'h7000 + 64'(8 * k), 32'(32'h700 + 16 * k));
    flush = 1; dec_rdy = 1;
    step(1, 1, 64'h7F00, 32'h7F, 32'h7E, 0, 0, '0, '0, 0, 0);
    flush = 0; dec_rdy = 0; q.delete();
    @(negedge clock);
    chk("flush_s0_valid", 192'(s0_v), 192'(1'b0));
    chk("flush_ready", 192'(rdy), 192'(1'b1));
    @(posedge clock); #1;
    for (int k = 0; k < 5; k++) pair(64'h8000 + 64'(8 * k), 32'(32'h800 + 16 * k));
    reset = 0; dec_rdy = 1; flush = 1;
    step(1, 1, 64'h8F00, 32'h8F, 32'h8E, 0, 0, '0, '0, 0, 0);
    reset = 1; dec_rdy = 0; flush = 0; q.delete();
    @(negedge clock);
    chk("rst_s0_valid", 192'(s0_v), 192'(1'b0));
    chk("rst_s1_valid", 192'(s1_v), 192'(1'b0));
    @(posedge clock); #1;
    step(1, 1, 64'h9000, 32'h90, 32'h91, 0, 0, '0, '0, 0, 1);
    @(negedge clock);
    chk("rst_after_s0_pc", 192'(s0_pc), 192'(64'h9000));
    @(posedge clock); #1;
    dec_rdy = 1; idle(2); dec_rdy = 0;
    idle(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, default 16, number of instruction entries; power of two, at least 4.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low; low at a rising edge clears state.
REQ-004 io_i_flush  input  1  discard all queued instructions.
REQ-005 io_i_fetch_pack_valid  input  1  fetch pack offered.
REQ-006 io_i_fetch_pack_bits_valids_0 / _1  input  1 each  per-slot instruction valid.
REQ-007 io_i_fetch_pack_bits_pc  input  64  8-byte-aligned pack PC.
REQ-008 io_i_fetch_pack_bits_insts_0 / _1  input  32 each  slot instructions.
REQ-009 io_i_fetch_pack_bits_branch_predict_pack_{valid,target,branch_type,select,taken}  input  1/64/4/1/1  prediction for the pack.
REQ-010 io_o_fetch_pack_ready  output  1  queue can accept a pack this cycle.
REQ-011 io_i_decode_ready  input  1  decode accepts presented slots.
REQ-012 io_o_slot_{0,1}_valid  output  1 each  slot holds an instruction.
REQ-013 io_o_slot_{0,1}_pc / _inst  output  64/32 each  instruction PC and word.
REQ-014 io_o_slot_{0,1}_bp_{valid,target,branch_type,taken}  output  1/64/4/1 each  prediction attached to that instruction.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH entries {pc, inst, bp_valid, bp_target, bp_type, bp_taken} with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
REQ-016 io_o_fetch_pack_ready SHALL equal (DEPTH - count >= 2), combinational from registered count only; it SHALL NOT depend on same-cycle dequeue.
REQ-017 Enqueue SHALL occur when fetch_pack_valid & fetch_pack_ready & ~flush.
REQ-018 On enqueue, valid slots SHALL be written compacted and in order at tail: slot0 with pc, slot1 with pc+4; tail and count advance by valids_0 + valids_1 (0, 1 or 2).
REQ-019 Only valids_1 set: a single entry (pc+4, insts_1) SHALL be written at tail.
REQ-020 An entry SHALL get bp_valid = predict_valid only if its slot index equals predict select; the other entry SHALL get bp_valid = 0; target/type/taken copied unchanged.
REQ-021 io_o_slot_0_valid = (count >= 1) SHALL present entry head; io_o_slot_1_valid = (count >= 2) SHALL present entry head+1 (mod DEPTH).
REQ-022 Slot outputs SHALL be driven from registered state; first enqueue to an empty queue SHALL appear at slot0 the next cycle (1-cycle latency, no bypass).
REQ-023 When io_i_decode_ready is high and ~flush, head SHALL advance and count decrease by slot_0_valid + slot_1_valid; all-or-nothing for presented slots.
REQ-024 Simultaneous enqueue and dequeue SHALL update count by (enqueued - dequeued) in one cycle.
REQ-025 Flush SHALL take priority: next cycle head = tail = count = 0, both slot valids 0, enqueue and dequeue in the flush cycle ignored.
REQ-026 decode_ready with count = 0 SHALL leave state unchanged; a fetch pack with both valids 0 SHALL be accepted but write nothing.
REQ-027 Invariant: count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-028 reset low at a clock edge SHALL set head = tail = count = 0; next cycle io_o_slot_{0,1}_valid = 0 and io_o_fetch_pack_ready = 1.
REQ-029 Reset SHALL override flush, enqueue and dequeue in the same cycle; entry contents need not be cleared.

Verification
REQ-030 Basic: pc=0x1000, valids=11, insts=0xA/0xB, decode_ready=0 -> next cycle slot0=(0x1000,0xA), slot1=(0x1004,0xB), count=2.
REQ-031 Misaligned: pc=0x2000, valids=01, insts_1=0xC -> single entry at slot0 = (0x2004, 0xC); slot1 invalid.
REQ-032 Fill: decode_ready=0, enqueue 8 two-inst packs (DEPTH=16) -> count=16, ready=0; pop two -> count=14, ready=1; head/tail wrap keeps order.
REQ-033 Branch attach: valids=11, predict valid=1, select=1, target=0x3000, taken=1 -> slot1 bp_valid=1, bp_target=0x3000; slot0 bp_valid=0.
REQ-034 Flush: count=6, flush with concurrent enqueue and decode_ready -> next cycle count=0, slot valids 0, ready=1, flushed pack not stored.
REQ-035 Reset mid-operation: count=10, reset low for one edge -> next cycle count=0, slot valids 0; following enqueue appears at slot0 one cycle later.
